// File: rtl/btn_press_classifier.sv
// Multi-channel button front end: 2-FF synchroniser, debounce and a short/long/repeat
// press classifier per channel. Channels are independent copies of the same datapath.
module btn_press_classifier #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 500_000_000,
  parameter int unsigned REPEAT_CYC   = 25_000_000,
  parameter bit          REPEAT_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] held,
  output logic [N_CH-1:0] short_p,
  output logic [N_CH-1:0] long_p,
  output logic [N_CH-1:0] rpt_p,
  output logic [N_CH-1:0] en
);

  localparam int unsigned DW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned HMAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int unsigned HW   = $clog2(HMAX);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] RPT_LAST  = HW'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_e;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    state_e        state_q;
    logic [HW-1:0] hcnt_q;
    logic          short_q, long_q, rpt_q;

    always_comb begin
      db_d   = db_q;
      dcnt_d = '0;
      if (sync2_q != db_q) begin
        if (dcnt_q == DB_LAST) db_d = sync2_q;
        else                   dcnt_d = dcnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        db_q    <= 1'b0;
        dcnt_q  <= '0;
      end else begin
        sync1_q <= btn_in[c];
        sync2_q <= sync1_q;
        db_q    <= db_d;
        dcnt_q  <= dcnt_d;
      end
    end

    // The classifier acts on db_d so its registered pulses line up with the
    // cycle in which held shows the same debounced level.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= IDLE;
        hcnt_q  <= '0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        short_q <= 1'b0;
        long_q  <= 1'b0;
        rpt_q   <= 1'b0;
        case (state_q)
          IDLE: begin
            if (db_d) begin
              state_q <= PRESS;
              hcnt_q  <= HW'(1);
            end
          end
          PRESS: begin
            if (!db_d) begin
              short_q <= 1'b1;
              state_q <= IDLE;
              hcnt_q  <= '0;
            end else if (hcnt_q == LONG_LAST) begin
              long_q  <= 1'b1;
              state_q <= LONG;
              hcnt_q  <= '0;
            end else begin
              hcnt_q <= hcnt_q + 1'b1;
            end
          end
          LONG: begin
            if (!db_d) begin
              state_q <= IDLE;
              hcnt_q  <= '0;
            end else if (REPEAT_EN && (hcnt_q == RPT_LAST)) begin
              rpt_q  <= 1'b1;
              hcnt_q <= '0;
            end else if (hcnt_q != RPT_LAST) begin
              hcnt_q <= hcnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            hcnt_q  <= '0;
          end
        endcase
      end
    end

    assign held[c]    = db_q;
    assign short_p[c] = short_q;
    assign long_p[c]  = long_q;
    assign rpt_p[c]   = rpt_q;
    assign en[c]      = db_q & ~long_q;
  end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Scoreboard bench: press schedules are turned into expected held windows and
// pulse events up front, then compared against two DUTs (auto-repeat on/off).
module tb_btn_press_classifier;
  localparam int NCH = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] btn = '0;
  logic [NCH-1:0] held, short_p, long_p, rpt_p, en;
  logic [NCH-1:0] held_nr, short_nr, long_nr, rpt_nr, en_nr;

  btn_press_classifier #(
    .N_CH(NCH), .DEBOUNCE_CYC(4), .LONG_CYC(20), .REPEAT_CYC(5), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn), .held(held), .short_p(short_p),
    .long_p(long_p), .rpt_p(rpt_p), .en(en)
  );

  btn_press_classifier #(
    .N_CH(NCH), .DEBOUNCE_CYC(4), .LONG_CYC(20), .REPEAT_CYC(5), .REPEAT_EN(1'b0)
  ) dut_nr (
    .clk(clk), .rst_n(rst_n), .btn_in(btn), .held(held_nr), .short_p(short_nr),
    .long_p(long_nr), .rpt_p(rpt_nr), .en(en_nr)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int s; int e; int lng; } iv_t;
  typedef struct { int cyc; int ch; int kind; } ev_t;   // kind 0 short, 1 long, 2 rpt

  iv_t ivq[$];
  ev_t sb[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int enc(int c, int ch, int kind);
    return c * 16 + ch * 4 + kind;
  endfunction

  function automatic bit in_held(int ch, int c);
    foreach (ivq[i]) if (ivq[i].ch == ch && c >= ivq[i].s && c <= ivq[i].e) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_long(int ch, int c);
    foreach (ivq[i]) if (ivq[i].ch == ch && ivq[i].lng == c) return 1'b1;
    return 1'b0;
  endfunction

  // Button driven at negedge of cycle k and released at negedge k+len:
  // held covers cycles k+6 .. k+len+5.
  function automatic void add_press(int ch, int k, int len);
    iv_t iv;
    iv.ch = ch; iv.s = k + 6; iv.e = k + len + 5; iv.lng = -1;
    if (len < 20) begin
      sb.push_back('{k + len + 6, ch, 0});
    end else begin
      iv.lng = k + 25;
      sb.push_back('{k + 25, ch, 1});
      for (int j = 1; 5 * j <= len - 20; j++) sb.push_back('{k + 25 + 5 * j, ch, 2});
    end
    ivq.push_back(iv);
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
      bit eh, el;
      eh = in_held(ch, cyc);
      el = is_long(ch, cyc);
      chk("held", 32'(held[ch]), 32'(eh));
      chk("en", 32'(en[ch]), 32'(eh & ~el));
      chk("nr_held", 32'(held_nr[ch]), 32'(eh));
      chk("nr_long", 32'(long_nr[ch]), 32'(el));
      chk("nr_rpt", 32'(rpt_nr[ch]), 32'd0);
    end
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk("missed_event", 32'd0, 32'(enc(sb[0].cyc, sb[0].ch, sb[0].kind)));
      void'(sb.pop_front());
    end
    for (int ch = 0; ch < NCH; ch++) begin
      for (int kind = 0; kind < 3; kind++) begin
        logic p;
        p = (kind == 0) ? short_p[ch] : (kind == 1) ? long_p[ch] : rpt_p[ch];
        if (p !== 1'b0) begin
          if (sb.size() == 0) begin
            chk("extra_event", 32'(enc(cyc, ch, kind)), 32'd0);
          end else begin
            chk("event", 32'(enc(cyc, ch, kind)), 32'(enc(sb[0].cyc, sb[0].ch, sb[0].kind)));
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    idle(3);
    chk("rst_held", 32'(held), 32'd0);
    chk("rst_pulses", 32'({short_p, long_p, rpt_p, en}), 32'd0);
    rst_n = 1'b1;
    idle(5);

    // glitch shorter than debounce window
    btn[0] = 1'b1; idle(3); btn[0] = 1'b0; idle(15);

    // short press
    k = cyc; add_press(0, k, 14);
    btn[0] = 1'b1; idle(14); btn[0] = 1'b0; idle(15);

    // long press with repeats
    k = cyc; add_press(0, k, 40);
    btn[0] = 1'b1; idle(40); btn[0] = 1'b0; idle(15);

    // both channels together, different lengths
    k = cyc; add_press(0, k, 10); add_press(1, k, 30);
    btn = 2'b11; idle(10); btn[0] = 1'b0; idle(20); btn[1] = 1'b0; idle(15);

    // reset in held cycle 15 with the button kept down
    k = cyc;
    ivq.push_back('{0, k + 6, k + 19, -1});
    btn[0] = 1'b1; idle(19);
    rst_n = 1'b0; idle(1);
    chk("midrst_outputs", 32'({held, short_p, long_p, rpt_p, en}), 32'd0);
    rst_n = 1'b1;
    k = cyc; add_press(0, k, 22);
    idle(22); btn[0] = 1'b0; idle(15);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout at cyc %0d", cyc);
    $fatal(1);
  end
endmodule
